// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 8-bit ALU. Owns an 8 x 8 register file, accepts one
// register-to-register command at a time, drives registered operands/opcode to the ALU,
// writes the result back and emits a one-cycle response strobe.
module alu_issue_ctrl #(
  parameter int unsigned NREGS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Cmd_Valid,
  output logic       Cmd_Ready,
  input  logic [3:0] Cmd_Op,
  input  logic [2:0] Cmd_Rd,
  input  logic [2:0] Cmd_Rs,
  input  logic [2:0] Cmd_Rt,
  input  logic       Ld_En,
  input  logic [2:0] Ld_Addr,
  input  logic [7:0] Ld_Data,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [3:0] ALU_Sel,
  input  logic [7:0] ALU_Out,
  input  logic       CarryOut,
  output logic       Rsp_Valid,
  output logic [7:0] Rsp_Data,
  output logic       Rsp_Carry,
  output logic       Rsp_Zero,
  output logic       Rsp_DivErr
);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpDiv = 4'b0011;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] rf_q [NREGS];
  logic [3:0] op_q;
  logic [2:0] rd_q, rs_q, rt_q;
  logic       diverr_q;

  logic       accept;
  logic [7:0] rs_val, rt_val, wb_val;
  logic       div_zero;

  assign Cmd_Ready = (state_q == StIdle) && !reset;
  assign accept    = Cmd_Valid && Cmd_Ready;

  // Operand read with register 0 hardwired to zero; divide guard and write-back value.
  always_comb begin
    rs_val   = (rs_q == 3'd0) ? 8'd0 : rf_q[rs_q];
    rt_val   = (rt_q == 3'd0) ? 8'd0 : rf_q[rt_q];
    div_zero = (op_q == OpDiv) && (rt_val == 8'd0);
    wb_val   = diverr_q ? 8'hFF : ALU_Out;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: fixed IDLE -> FETCH -> EXEC -> DONE ring, leaving IDLE only on accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StFetch;
      StFetch: state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: command latch, load port, operand issue, write-back and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= 8'd0;
      op_q       <= 4'd0;
      rd_q       <= 3'd0;
      rs_q       <= 3'd0;
      rt_q       <= 3'd0;
      diverr_q   <= 1'b0;
      ALU_A      <= 8'd0;
      ALU_B      <= 8'd0;
      ALU_Sel    <= 4'd0;
      Rsp_Valid  <= 1'b0;
      Rsp_Data   <= 8'd0;
      Rsp_Carry  <= 1'b0;
      Rsp_Zero   <= 1'b0;
      Rsp_DivErr <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Load commits on the accept edge too, so the following FETCH sees it.
          if (Ld_En && (Ld_Addr != 3'd0)) rf_q[Ld_Addr] <= Ld_Data;
          if (accept) begin
            op_q <= Cmd_Op;
            rd_q <= Cmd_Rd;
            rs_q <= Cmd_Rs;
            rt_q <= Cmd_Rt;
          end
        end
        StFetch: begin
          ALU_A    <= rs_val;
          // Substitute 1 for a zero divisor so the ALU never sees x/0.
          ALU_B    <= div_zero ? 8'd1 : rt_val;
          ALU_Sel  <= op_q;
          diverr_q <= div_zero;
        end
        StExec: begin
          if (rd_q != 3'd0) rf_q[rd_q] <= wb_val;
          Rsp_Data   <= wb_val;
          Rsp_Carry  <= (op_q == OpAdd) && CarryOut;
          Rsp_Zero   <= (wb_val == 8'd0);
          Rsp_DivErr <= diverr_q;
          Rsp_Valid  <= 1'b1;
        end
        StDone: begin
          Rsp_Valid <= 1'b0;
        end
        default: begin
          Rsp_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 8-bit ALU on the operand side.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       Cmd_Valid;
  logic       Cmd_Ready;
  logic [3:0] Cmd_Op;
  logic [2:0] Cmd_Rd, Cmd_Rs, Cmd_Rt;
  logic       Ld_En;
  logic [2:0] Ld_Addr;
  logic [7:0] Ld_Data;
  logic [7:0] ALU_A, ALU_B;
  logic [3:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       CarryOut;
  logic       Rsp_Valid;
  logic [7:0] Rsp_Data;
  logic       Rsp_Carry, Rsp_Zero, Rsp_DivErr;

  int n_checks = 0;
  int n_fails  = 0;

  alu_issue_ctrl #(.NREGS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .Cmd_Valid  (Cmd_Valid),
    .Cmd_Ready  (Cmd_Ready),
    .Cmd_Op     (Cmd_Op),
    .Cmd_Rd     (Cmd_Rd),
    .Cmd_Rs     (Cmd_Rs),
    .Cmd_Rt     (Cmd_Rt),
    .Ld_En      (Ld_En),
    .Ld_Addr    (Ld_Addr),
    .Ld_Data    (Ld_Data),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_Sel    (ALU_Sel),
    .ALU_Out    (ALU_Out),
    .CarryOut   (CarryOut),
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_Data   (Rsp_Data),
    .Rsp_Carry  (Rsp_Carry),
    .Rsp_Zero   (Rsp_Zero),
    .Rsp_DivErr (Rsp_DivErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-bit ALU; carry is the add carry regardless of opcode.
  logic [8:0] sum9;
  always_comb begin
    sum9     = {1'b0, ALU_A} + {1'b0, ALU_B};
    CarryOut = sum9[8];
    ALU_Out  = 8'd0;
    case (ALU_Sel)
      4'h0: ALU_Out = ALU_A + ALU_B;
      4'h1: ALU_Out = ALU_A - ALU_B;
      4'h2: ALU_Out = ALU_A * ALU_B;
      4'h3: ALU_Out = (ALU_B != 8'd0) ? ALU_A / ALU_B : 8'd0;
      4'h4: ALU_Out = ALU_A << 1;
      4'h5: ALU_Out = ALU_A >> 1;
      4'h6: ALU_Out = {ALU_A[6:0], ALU_A[7]};
      4'h7: ALU_Out = {ALU_A[0], ALU_A[7:1]};
      4'h8: ALU_Out = ALU_A & ALU_B;
      4'h9: ALU_Out = ALU_A | ALU_B;
      4'hA: ALU_Out = ALU_A ^ ALU_B;
      4'hB: ALU_Out = ~(ALU_A | ALU_B);
      4'hC: ALU_Out = ~(ALU_A & ALU_B);
      4'hD: ALU_Out = ~(ALU_A ^ ALU_B);
      4'hE: ALU_Out = (ALU_A > ALU_B) ? 8'd1 : 8'd0;
      4'hF: ALU_Out = (ALU_A == ALU_B) ? 8'd1 : 8'd0;
      default: ALU_Out = 8'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    Ld_En   = 1'b1;
    Ld_Addr = addr;
    Ld_Data = data;
    @(posedge clk);
    #1 Ld_En = 1'b0;
  endtask

  // ld_mode: 0 none, 1 load on the accept edge, 2 load attempted during FETCH.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input int ld_mode, input logic [2:0] la,
                       input logic [7:0] ld, output logic [7:0] data, output logic c,
                       output logic z, output logic de, output logic [7:0] exec_b);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!Cmd_Ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 8) check("ready_timeout", 32'(Cmd_Ready), 32'd1);
    Cmd_Valid = 1'b1;
    Cmd_Op    = op;
    Cmd_Rd    = rd;
    Cmd_Rs    = rs;
    Cmd_Rt    = rt;
    if (ld_mode == 1) begin
      Ld_En = 1'b1; Ld_Addr = la; Ld_Data = ld;
    end
    @(posedge clk);                       // e0
    #1 Cmd_Valid = 1'b0;
    Ld_En = 1'b0;
    if (ld_mode == 2) begin
      Ld_En = 1'b1; Ld_Addr = la; Ld_Data = ld;
    end
    @(negedge clk);
    check("rsp_early_fetch", 32'(Rsp_Valid), 32'd0);
    @(posedge clk);                       // e1
    #1 Ld_En = 1'b0;
    @(negedge clk);
    exec_b = ALU_B;
    check("alu_sel_exec", 32'(ALU_Sel), 32'(op));
    check("rsp_early_exec", 32'(Rsp_Valid), 32'd0);
    @(posedge clk);                       // e2
    @(negedge clk);
    check("rsp_valid_done", 32'(Rsp_Valid), 32'd1);
    data = Rsp_Data;
    c    = Rsp_Carry;
    z    = Rsp_Zero;
    de   = Rsp_DivErr;
    @(posedge clk);                       // e3
    @(negedge clk);
    check("rsp_valid_drop", 32'(Rsp_Valid), 32'd0);
    check("ready_after_e3", 32'(Cmd_Ready), 32'd1);
  endtask

  // Register readback through add Rd=0 Rs=r Rt=0, which has no side effects.
  task automatic read_reg(input logic [2:0] r, output logic [7:0] v);
    logic c, z, de;
    logic [7:0] b;
    issue(4'h0, 3'd0, r, 3'd0, 0, 3'd0, 8'd0, v, c, z, de, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, b, v;
    logic c, z, de;

    reset = 1'b1; Cmd_Valid = 1'b0; Cmd_Op = 4'd0; Cmd_Rd = 3'd0; Cmd_Rs = 3'd0;
    Cmd_Rt = 3'd0; Ld_En = 1'b0; Ld_Addr = 3'd0; Ld_Data = 8'd0;

    @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 32'(Cmd_Ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(Cmd_Ready), 32'd1);
    check("reset_alu_a", 32'(ALU_A), 32'd0);
    check("reset_alu_b", 32'(ALU_B), 32'd0);
    check("reset_alu_sel", 32'(ALU_Sel), 32'd0);
    check("reset_rsp", {Rsp_Valid, Rsp_Carry, Rsp_Zero, Rsp_DivErr, Rsp_Data}, 32'd0);

    // Carry case: 200 + 100 = 300 -> 44 with carry.
    load(3'd1, 8'd200);
    load(3'd2, 8'd100);
    issue(4'h0, 3'd3, 3'd1, 3'd2, 0, 3'd0, 8'd0, d, c, z, de, b);
    check("add_data", 32'(d), 32'd44);
    check("add_carry", 32'(c), 32'd1);
    check("add_zero", 32'(z), 32'd0);
    read_reg(3'd3, v);
    check("add_wb_r3", 32'(v), 32'd44);

    // Divide by zero, then a legal divide 200/7 = 28.
    load(3'd4, 8'd0);
    issue(4'h3, 3'd5, 3'd1, 3'd4, 0, 3'd0, 8'd0, d, c, z, de, b);
    check("div0_alu_b", 32'(b), 32'd1);
    check("div0_data", 32'(d), 32'hFF);
    check("div0_err", 32'(de), 32'd1);
    read_reg(3'd5, v);
    check("div0_wb_r5", 32'(v), 32'hFF);
    load(3'd6, 8'd7);
    issue(4'h3, 3'd5, 3'd1, 3'd6, 0, 3'd0, 8'd0, d, c, z, de, b);
    check("div_data", 32'(d), 32'd28);
    check("div_err", 32'(de), 32'd0);
    check("div_alu_b", 32'(b), 32'd7);

    // r0 protection.
    load(3'd0, 8'd55);
    load(3'd1, 8'd9);
    load(3'd2, 8'd9);
    issue(4'h1, 3'd0, 3'd1, 3'd2, 0, 3'd0, 8'd0, d, c, z, de, b);
    check("sub_data", 32'(d), 32'd0);
    check("sub_zero", 32'(z), 32'd1);
    issue(4'h0, 3'd7, 3'd0, 3'd0, 0, 3'd0, 8'd0, d, c, z, de, b);
    check("r0_read_data", 32'(d), 32'd0);
    check("r0_read_zero", 32'(z), 32'd1);

    // Back-to-back with Cmd_Valid held; second command depends on first.
    load(3'd1, 8'h40);
    load(3'd2, 8'h41);
    @(negedge clk);
    Cmd_Valid = 1'b1; Cmd_Op = 4'h0; Cmd_Rd = 3'd3; Cmd_Rs = 3'd1; Cmd_Rt = 3'd2;
    @(posedge clk);                       // e0
    #1 Cmd_Op = 4'h6; Cmd_Rd = 3'd4; Cmd_Rs = 3'd3; Cmd_Rt = 3'd0;
    @(negedge clk);
    check("b2b_busy_fetch", 32'(Cmd_Ready), 32'd0);
    @(posedge clk);
    @(posedge clk);                       // e2
    @(negedge clk);
    check("b2b_rsp1_valid", 32'(Rsp_Valid), 32'd1);
    check("b2b_rsp1_data", 32'(Rsp_Data), 32'h81);
    @(posedge clk);                       // e3
    @(negedge clk);
    check("b2b_ready_e3", 32'(Cmd_Ready), 32'd1);
    @(posedge clk);                       // e4 accept
    #1 Cmd_Valid = 1'b0;
    @(negedge clk);
    check("b2b_accepted_e4", 32'(Cmd_Ready), 32'd0);
    check("b2b_no_rsp_e4", 32'(Rsp_Valid), 32'd0);
    @(posedge clk);
    @(posedge clk);                       // e6
    @(negedge clk);
    check("b2b_rsp2_valid", 32'(Rsp_Valid), 32'd1);
    check("b2b_rsp2_data", 32'(Rsp_Data), 32'h03);
    check("b2b_rsp2_carry", 32'(Rsp_Carry), 32'd0);
    @(posedge clk);

    // Compare ops and carry gating for non-add opcodes.
    load(3'd1, 8'h5A);
    load(3'd2, 8'h5A);
    issue(4'hF, 3'd7, 3'd1, 3'd2, 0, 3'd0, 8'd0, d, c, z, de, b);
    check("eq_data", 32'(d), 32'd1);
    check("eq_zero", 32'(z), 32'd0);
    check("eq_carry", 32'(c), 32'd0);
    load(3'd1, 8'd3);
    load(3'd2, 8'd9);
    issue(4'hE, 3'd7, 3'd1, 3'd2, 0, 3'd0, 8'd0, d, c, z, de, b);
    check("gt_data", 32'(d), 32'd0);
    check("gt_zero", 32'(z), 32'd1);
    load(3'd1, 8'd200);
    load(3'd2, 8'd100);
    issue(4'hE, 3'd7, 3'd1, 3'd2, 0, 3'd0, 8'd0, d, c, z, de, b);
    check("gt_true_data", 32'(d), 32'd1);
    check("gt_carry_gated", 32'(c), 32'd0);

    // Load alongside accept is seen by FETCH; load during FETCH is ignored.
    issue(4'h0, 3'd0, 3'd6, 3'd0, 1, 3'd6, 8'h20, d, c, z, de, b);
    check("ld_on_accept", 32'(d), 32'h20);
    load(3'd5, 8'h11);
    issue(4'h0, 3'd0, 3'd1, 3'd2, 2, 3'd5, 8'h77, d, c, z, de, b);
    read_reg(3'd5, v);
    check("ld_in_fetch_ignored", 32'(v), 32'h11);

    // Reset during EXEC aborts the command.
    load(3'd1, 8'd5);
    load(3'd2, 8'd6);
    @(negedge clk);
    Cmd_Valid = 1'b1; Cmd_Op = 4'h0; Cmd_Rd = 3'd6; Cmd_Rs = 3'd1; Cmd_Rt = 3'd2;
    @(posedge clk);                       // e0
    #1 Cmd_Valid = 1'b0;
    @(posedge clk);                       // e1
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_exec_ready", 32'(Cmd_Ready), 32'd0);
    @(posedge clk);                       // e2 under reset
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready_after", 32'(Cmd_Ready), 32'd1);
    check("rst_alu_a", 32'(ALU_A), 32'd0);
    check("rst_alu_b", 32'(ALU_B), 32'd0);
    check("rst_alu_sel", 32'(ALU_Sel), 32'd0);
    check("rst_rsp", {Rsp_Valid, Rsp_Carry, Rsp_Zero, Rsp_DivErr, Rsp_Data}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_pulse", 32'(Rsp_Valid), 32'd0);
    end
    read_reg(3'd6, v);
    check("rst_rd_unchanged", 32'(v), 32'd0);
    read_reg(3'd1, v);
    check("rst_rf_cleared", 32'(v), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-driven issue controller that sits on the operand/opcode side of the 8-bit `ALU`. It owns an 8-entry × 8-bit register file and accepts one register-to-register command at a time over a valid/ready handshake. For each command it drives `A`, `B` and `ALU_Sel` into the ALU, captures `ALU_Out` and `CarryOut`, writes the result back, and emits a one-cycle response. It is the sequential front end that the datapath control path uses to reach the ALU.

## Interface
- `NREGS`, 8: register-file depth; address width is 3 bits, fixed.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `Cmd_Valid` input 1: a command is presented.
- `Cmd_Ready` output 1: controller accepts a command; equals (state==IDLE) && !reset.
- `Cmd_Op` input 4: operation, in `ALU_Sel` encoding (0000 add … 1111 equal).
- `Cmd_Rd`, `Cmd_Rs`, `Cmd_Rt` input 3 each: destination, source A and source B register indices.
- `Ld_En`, `Ld_Addr[2:0]`, `Ld_Data[7:0]` input: direct register-file load port.
- `ALU_A`, `ALU_B` output 8: registered operands to the ALU.
- `ALU_Sel` output 4: registered opcode to the ALU.
- `ALU_Out` input 8, `CarryOut` input 1: ALU results.
- `Rsp_Valid` output 1: one-cycle response strobe.
- `Rsp_Data` output 8: the written-back result.
- `Rsp_Carry`, `Rsp_Zero`, `Rsp_DivErr` output 1 each: response flags.

## Operation
- FSM states: IDLE → FETCH → EXEC → DONE → IDLE. No other transitions exist except through reset.
- IDLE: command accepted on the edge where Cmd_Valid && Cmd_Ready. That edge latches Op, Rd, Rs and Rt, and the FSM moves to FETCH. Cmd_* is don't-care outside acceptance.
- FETCH edge: `ALU_A`←rf[Rs], `ALU_B`←rf[Rt], `ALU_Sel`←Op; FSM moves to EXEC.
- Register 0 always reads 8'd0. Writes to register 0, from a command or from `Ld_En`, are discarded.
- Divide guard: if Op==0011 and rf[Rt]==0, the FETCH edge drives `ALU_B`←8'd1 instead, to keep X out of the ALU, and sets an internal diverr flag.
- EXEC edge:
  - rf[Rd] and `Rsp_Data` ← `ALU_Out`, or 8'hFF when diverr is set.
  - `Rsp_Carry` ← `CarryOut` when Op==0000, else 0.
  - `Rsp_Zero` ← (written value == 0).
  - `Rsp_DivErr` ← diverr.
  - `Rsp_Valid` ← 1; FSM moves to DONE.
- DONE edge: `Rsp_Valid` ← 0; FSM moves to IDLE. `Rsp_Data` and the flags hold until the next EXEC edge.
- Load port is honoured only while the state is IDLE; it is ignored in any other state.
  - Ld_En in the same IDLE cycle as a command acceptance: the load commits on that edge, and the command's FETCH sees the loaded value.
- Commands are strictly serial. A command whose Rs or Rt equals the previous Rd reads the written-back value; no hazard exists.

## Timing
- Reset (applied on the edge with `reset`=1):
  - state IDLE; all rf entries 0.
  - `ALU_A`, `ALU_B`, `ALU_Sel` = 0.
  - `Rsp_Valid`, `Rsp_Data`, `Rsp_Carry`, `Rsp_Zero`, `Rsp_DivErr` = 0.
  - `Cmd_Ready` = 0 while `reset` is high, and 1 in the first cycle after.
- Latency, with acceptance at edge e0:
  - `ALU_A`/`ALU_B`/`ALU_Sel` valid after e1.
  - `ALU_Out` is sampled at e2, so the combinational ALU has one full cycle.
  - `Rsp_Valid` is high for exactly the cycle between e2 and e3.
  - `Cmd_Ready` is high again after e3.
- Throughput is one command per 4 cycles. A Cmd_Valid held high is accepted at e0, e4, e8, and so on.
- Reset in any state aborts the command: no `Rsp_Valid` and no write-back, and the rf is cleared.
- No back-pressure on the response; a consumer must sample `Rsp_*` during the `Rsp_Valid` cycle.

## Test plan
- Carry case: load r1=200, r2=100; issue add (0000) Rd=3 Rs=1 Rt=2 → `Rsp_Valid` exactly one cycle at e2–e3, `Rsp_Data`=44, `Rsp_Carry`=1, `Rsp_Zero`=0, r3=44.
- Divide by zero: r4=0, r1=200; issue 0011 Rd=5 Rs=1 Rt=4 → `ALU_B`=1 during EXEC, `Rsp_Data`=8'hFF, `Rsp_DivErr`=1, r5=8'hFF. Then issue 0011 with r6=7, r1=200 → `Rsp_Data`=28, `Rsp_DivErr`=0.
- r0 protection: `Ld_En` with Ld_Addr=0, Ld_Data=55, then sub (0001) Rd=0 Rs=1 Rt=2 with r1=9, r2=9 → `Rsp_Data`=0, `Rsp_Zero`=1. Then add Rd=7 Rs=0 Rt=0 → `Rsp_Data`=0.
- Back-to-back dependency: Cmd_Valid held high. First command: add r3=r1+r2 with r1=0x40, r2=0x41, giving 0x81. Second command: rotate-left (0110) Rd=4 Rs=3, accepted exactly 4 cycles later → `Rsp_Data`=0x03.
- Compare and flags: r1=r2=0x5A with equal (1111) → `Rsp_Data`=1, `Rsp_Zero`=0, `Rsp_Carry`=0 (op is not add). Greater (1110) with r1=3, r2=9 → `Rsp_Data`=0, `Rsp_Zero`=1.
- Reset mid-operation: assert `reset` in EXEC → no `Rsp_Valid` pulse, Rd unchanged (0), all outputs 0; `Cmd_Ready`=1 in the first cycle after `reset` drops. `Ld_En` asserted in FETCH is ignored.
